// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the 128-bit test memory port.
// Holds the copy-engine state enum and the access size encoding.
package mem_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DATA,
        ST_WRITE,
        ST_FIN
    } state_t;

    localparam logic [15:0] EN_B1  = 16'h0001;
    localparam logic [15:0] EN_B2  = 16'h0003;
    localparam logic [15:0] EN_B4  = 16'h000F;
    localparam logic [15:0] EN_B8  = 16'h00FF;
    localparam logic [15:0] EN_B16 = 16'hFFFF;

    // mis: OR of src/dst low bits; cap: remaining bytes clipped to 16
    function automatic logic [4:0] size_from_align(
        input logic [3:0] mis,
        input logic [4:0] cap
    );
        if (mis == 4'd0 && cap >= 5'd16)
            return 5'd16;
        else if (mis[2:0] == 3'd0 && cap >= 5'd8)
            return 5'd8;
        else if (mis[1:0] == 2'd0 && cap >= 5'd4)
            return 5'd4;
        else if (mis[0] == 1'b0 && cap >= 5'd2)
            return 5'd2;
        else
            return 5'd1;
    endfunction

    function automatic logic [15:0] en_from_size(input logic [4:0] s);
        unique case (s)
            5'd16:   return EN_B16;
            5'd8:    return EN_B8;
            5'd4:    return EN_B4;
            5'd2:    return EN_B2;
            default: return EN_B1;
        endcase
    endfunction

endpackage

// File: rtl/mem_copy_initiator_if.sv
// Requester-side bundle of the 128-bit unaligned memory port.
// The memory answers a read with right-aligned data one cycle later.
interface mem_copy_initiator_if #(
    parameter int ADDR_W = 8
);
    logic [15:0]       en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [127:0]      wdata;
    logic [127:0]      rdata;

    modport master (
        output en, we, addr, wdata,
        input  rdata
    );

    modport slave (
        input  en, we, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/mem_chunk_sizer.sv
// Picks the largest naturally aligned chunk (16/8/4/2/1 bytes)
// that fits both addresses and the remaining byte count.
module mem_chunk_sizer
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  rem,
    output logic [4:0]        size,
    output logic [15:0]       mask
);
    logic [LEN_W+4:0] remx;
    logic [4:0]       cap;

    assign remx = {5'd0, rem};
    assign cap  = (remx >= (LEN_W+5)'(16)) ? 5'd16 : remx[4:0];
    assign size = size_from_align(src[3:0] | dst[3:0], cap);
    assign mask = en_from_size(size);
endmodule

// File: rtl/mem_copy_initiator.sv
// Copy engine: moves a byte range on one single-port memory as a
// sequence of aligned read/data/write chunks, three cycles each.
module mem_copy_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  bytes_done,
    mem_copy_initiator_if.master mem
);
    state_t            state, nxt;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  rem_q, bytes_q, sz_l, rem_nxt;
    logic [127:0]      buf_q, rmask;
    logic              abrt_q;
    logic [4:0]        sz;
    logic [15:0]       en_mask;

    mem_chunk_sizer #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_sizer (
        .src (src_q),
        .dst (dst_q),
        .rem (rem_q),
        .size(sz),
        .mask(en_mask)
    );

    assign sz_l    = LEN_W'(sz);
    assign rem_nxt = rem_q - sz_l;

    always_comb begin
        rmask = '0;
        for (int i = 0; i < 16; i++)
            rmask[i*8 +: 8] = {8{en_mask[i]}};
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (start) nxt = (len != '0) ? ST_READ : ST_FIN;
            ST_READ:  nxt = abort ? ST_FIN : ST_DATA;
            ST_DATA:  nxt = abort ? ST_FIN : ST_WRITE;
            ST_WRITE: nxt = (abort || rem_nxt == '0) ? ST_FIN : ST_READ;
            ST_FIN:   nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.en    = '0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        unique case (state)
            ST_READ: begin
                mem.en   = en_mask;
                mem.addr = src_q;
            end
            ST_WRITE: begin
                mem.en    = en_mask;
                mem.we    = 1'b1;
                mem.addr  = dst_q;
                mem.wdata = buf_q;
            end
            default: ;
        endcase
    end

    assign busy       = (state == ST_READ) || (state == ST_DATA)
                     || (state == ST_WRITE);
    assign done       = (state == ST_FIN);
    assign aborted    = abrt_q;
    assign bytes_done = bytes_q;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state   <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            bytes_q <= '0;
            buf_q   <= '0;
            abrt_q  <= 1'b0;
        end else begin
            state <= nxt;
            unique case (state)
                ST_IDLE: if (start) begin
                    src_q   <= src_addr;
                    dst_q   <= dst_addr;
                    rem_q   <= len;
                    bytes_q <= '0;
                    abrt_q  <= 1'b0;
                end
                ST_READ: if (abort) abrt_q <= 1'b1;
                ST_DATA: begin
                    if (abort) abrt_q <= 1'b1;
                    else       buf_q  <= mem.rdata & rmask;
                end
                ST_WRITE: begin
                    src_q   <= src_q + ADDR_W'(sz);
                    dst_q   <= dst_q + ADDR_W'(sz);
                    rem_q   <= rem_nxt;
                    bytes_q <= bytes_q + sz_l;
                    if (abort) abrt_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_initiator.sv
// Randomized bench for mem_copy_initiator against a byte-level
// reference of the copy and a cycle trace of the expected accesses.
module tb_mem_copy_initiator;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clka = 1'b0;
    logic          rsta_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, aborted;
    logic [LW-1:0] bytes_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram [256];
    logic [7:0] ref_ram [256];

    mem_copy_initiator_if #(.ADDR_W(AW)) mem ();

    mem_copy_initiator #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .bytes_done(bytes_done),
        .mem       (mem.master)
    );

    always #5 clka = ~clka;

    // memory model: byte-enable write, registered right-aligned read
    always @(posedge clka) begin
        if (mem.en != 16'd0) begin
            for (int k = 0; k < 16; k++) begin
                logic [7:0] a;
                a = mem.addr + 8'(k);
                if (mem.we) begin
                    if (mem.en[k]) ram[a] = mem.wdata[k*8 +: 8];
                end else begin
                    mem.rdata[k*8 +: 8] <= mem.en[k] ? ram[a] : 8'h00;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] pk(input logic b, input logic dn,
        input logic [15:0] en, input logic we, input logic [7:0] a,
        input logic [127:0] wd);
        return {5'd0, b, dn, en, we, a, wd};
    endfunction

    function automatic logic [159:0] obs_now();
        return pk(busy, done, mem.en, mem.we, mem.addr, mem.wdata);
    endfunction

    task automatic drain();
        for (int i = 0; i < 100 && (busy || done); i++)
            @(posedge clka) #1;
        if (busy || done) chk("drain", 160'(busy), 160'd0);
    endtask

    // ab: cycle (1 = first after start) in which abort is held, 0 = none
    task automatic run(input int s, input int d, input int l,
                       input int ab, input bit poke);
        logic [159:0] tr[$];
        int cs, cd, rem, cyc, nb, sz, diffs;
        bit stop, ab_flag;
        logic [127:0] data;
        logic [15:0] en;
        cs = s; cd = d; rem = l; cyc = 0; nb = 0;
        stop = 0; ab_flag = 0;
        while (rem > 0 && !stop) begin
            sz = 16;
            while (!((cs % sz) == 0 && (cd % sz) == 0 && sz <= rem))
                sz = sz / 2;
            en = 16'((32'd1 << sz) - 1);
            data = '0;
            for (int k = 0; k < sz; k++)
                data[k*8 +: 8] = ref_ram[(cs + k) % 256];
            cyc++;
            tr.push_back(pk(1, 0, en, 0, 8'(cs), '0));
            if (cyc == ab) begin stop = 1; ab_flag = 1; break; end
            cyc++;
            tr.push_back(pk(1, 0, 16'd0, 0, 8'd0, '0));
            if (cyc == ab) begin stop = 1; ab_flag = 1; break; end
            cyc++;
            tr.push_back(pk(1, 0, en, 1, 8'(cd), data));
            for (int k = 0; k < sz; k++)
                ref_ram[(cd + k) % 256] = data[k*8 +: 8];
            nb += sz;
            cs = (cs + sz) % 256;
            cd = (cd + sz) % 256;
            rem -= sz;
            if (cyc == ab) begin ab_flag = 1; stop = 1; end
        end
        tr.push_back(pk(0, 1, 16'd0, 0, 8'd0, '0));

        drain();
        @(negedge clka);
        src_addr = 8'(s);
        dst_addr = 8'(d);
        len = 8'(l);
        start = 1'b1;
        @(posedge clka) #1;
        start = 1'b0;
        for (int c = 1; c <= tr.size(); c++) begin
            chk($sformatf("cyc%0d", c), obs_now(), tr[c-1]);
            if (c == tr.size()) begin
                chk("bytes", 160'(bytes_done), 160'(nb));
                chk("aborted", 160'(aborted), 160'(ab_flag));
            end else begin
                abort = (c == ab);
                if (poke && c == 2) begin
                    start = 1'b1;
                    src_addr = 8'hA5;
                    dst_addr = 8'h11;
                    len = 8'd3;
                end
                @(posedge clka) #1;
                abort = 1'b0;
                start = 1'b0;
            end
        end
        @(posedge clka) #1;
        chk("hold", {150'd0, busy, done, bytes_done},
            {150'd0, 1'b0, 1'b0, 8'(nb)});
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== ref_ram[i]) diffs++;
        chk("mem", 160'(diffs), 160'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            ref_ram[i] = ram[i];
        end
        #1;
        chk("reset", {busy, done, aborted, bytes_done, mem.en, mem.we,
                      mem.addr, mem.wdata}, 160'd0);
        @(negedge clka);
        rsta_n = 1'b1;

        run(8'h00, 8'h40, 32, 0, 0);
        run(8'h03, 8'h13, 13, 0, 0);
        run(8'h01, 8'h02, 4, 0, 0);
        run(8'h00, 8'h20, 7, 0, 0);
        run(8'h00, 8'h80, 0, 0, 0);
        run(8'h00, 8'h40, 48, 5, 0);
        run(8'h10, 8'h90, 32, 0, 1);
        run(8'h04, 8'h44, 20, 3, 0);

        for (int n = 0; n < 25; n++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            run($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 40), ab, n[0]);
        end

        // reset in the middle of a transfer
        drain();
        @(negedge clka);
        src_addr = 8'h00;
        dst_addr = 8'h60;
        len = 8'd32;
        start = 1'b1;
        @(posedge clka) #1;
        start = 1'b0;
        repeat (3) @(posedge clka) #1;
        rsta_n = 1'b0;
        #1;
        chk("rst_mid", {busy, done, aborted, bytes_done, mem.en, mem.we,
                        mem.addr, mem.wdata}, 160'd0);
        repeat (2) @(posedge clka) #1;
        @(negedge clka);
        rsta_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clka) #1;
            chk("no_done", {158'd0, busy, done}, 160'd0);
        end
        for (int i = 0; i < 256; i++) ref_ram[i] = ram[i];
        run(8'h08, 8'hF8, 24, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Requester-side engine for the 128-bit unaligned RRAM/AHB test memory port (clka, ena[15:0] size mask, wea, byte address, 128-bit din/dout, 1-cycle registered read).
- Copies a byte range from a source address to a destination address on the same single-port memory.
- Splits the copy into naturally aligned accesses of 1/2/4/8/16 bytes, issuing a read and then a write for each chunk.
- Sits between the SDMA descriptor logic and the memory model/controller.

Parameters:
- ADDR_W, 8, byte address width; must be ≥ 5.
- LEN_W, 8, transfer length width in bytes.

Ports:
- clka  in  1  clock
- rsta_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; captured on start
- dst_addr  in  ADDR_W  destination byte address; captured on start
- len  in  LEN_W  byte count; captured on start
- abort  in  1  cancel current transfer
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done; 1 = transfer was cancelled
- bytes_done  out  LEN_W  bytes written so far in the current/last transfer
- mem_en  out  16  access size mask: 0x0001, 0x0003, 0x000F, 0x00FF or 0xFFFF
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  access byte address
- mem_wdata  out  128  write data, right-aligned, upper bits zero
- mem_rdata  in  128  read data, right-aligned, valid the cycle after a read

Behaviour:
- Reset values (async, rsta_n low): state IDLE, busy 0, done 0, aborted 0, bytes_done 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
- All outputs are registered or decoded from registered state.
- States: IDLE, READ, DATA, WRITE, FIN.
- IDLE:
  - start=1 with len≠0 → latch src/dst/rem=len, clear bytes_done, go to READ.
  - start=1 with len=0 → go to FIN, no memory access.
- Chunk size s = largest of {16,8,4,2,1} such that src%s==0, dst%s==0 and s≤rem.
- s is computed combinationally from the latched registers.
- mem_en = (1<<s)-1.
- READ (one cycle): mem_addr=src, mem_we=0, mem_en per s → DATA.
- DATA (one cycle): mem_en=0, mem_we=0. Latch mem_rdata masked to s bytes into the data buffer → WRITE.
- WRITE (one cycle): mem_addr=dst, mem_we=1, mem_en per s, mem_wdata=buffer.
  - At the end of the cycle: src+=s, dst+=s (both wrap mod 2^ADDR_W), rem-=s, bytes_done+=s.
  - Next state is FIN if rem becomes 0, else READ.
- Each chunk takes exactly 3 cycles.
- Outside READ/WRITE: mem_en=0, mem_we=0.
- FIN (one cycle): done=1, busy=0 → IDLE.
- busy=1 exactly in READ/DATA/WRITE.
- abort:
  - Sampled in READ or DATA: go to FIN with aborted=1. No write is issued for that chunk.
  - Sampled in WRITE: the write completes, then go to FIN with aborted=1.
  - Ignored in IDLE/FIN.
- aborted is held with done; it is cleared on the next accepted start.
- start while busy or in FIN is ignored.
- bytes_done holds its value after done until the next accepted start.
- Reset during a transfer aborts immediately with no done pulse. A write driven in that cycle is lost.
- Overlapping src/dst ranges are copied in forward order; no overlap protection.

Decomposition:
- Shared package mem_if_pkg:
  - state enum
  - size-mask constants EN_B1/EN_B2/EN_B4/EN_B8/EN_B16
  - a function for size-from-alignment
- Natural sub-module: mem_chunk_sizer (combinational: src, dst, rem → s and mask), reused by the future write-back engine.

Test Plan:
- src=0x00, dst=0x40, len=32 → two chunks of 16 bytes; mem_en=0xFFFF. Writes to 0x40 then 0x50. done in the 7th cycle after start; bytes_done=32; memory words 4,5 equal words 0,1.
- src=0x03, dst=0x13, len=13 → chunks 1@0x03, 4@0x04, 8@0x08; masks 0x0001, 0x000F, 0x00FF. Destination bytes 0x13..0x1F match; neighbouring bytes untouched.
- src=0x01, dst=0x02, len=4 → four 1-byte chunks, all mem_en=0x0001; done 13 cycles after start.
- src=0x00, dst=0x20, len=7 → chunks 4, 2, 1.
- len=0 → done next cycle, busy never 1, mem_en stays 0.
- Abort asserted in the DATA cycle of chunk 2 of a 48-byte aligned copy → no second write; done with aborted=1; bytes_done=16.
- start pulsed while busy → ignored, result unchanged.
- rsta_n low mid-transfer → all outputs 0 immediately, no done pulse.
